tim_ctrl: RTL and testbench
===========================

// Module: tim_ctrl
// PURPOSE
//  Memory-mapped control front-end for the PWM timer core (tim). Holds preload/active config regs,
//  applies PSC/ARR/CCR atomically on the counter update event, and sequences the timer reset on
//  enable, mode change and software update. Raises the update interrupt; supports one-pulse mode.
// PARAMETERS
//  W           16  timer width (prescaler/period/pulse)
//  RST_CYCLES  2   cycles tim_rst is held high on each restart (>=1)
// PORTS
//  clk                in   1   system clock (single clock domain)
//  rst                in   1   synchronous, active-high reset
//  bus_addr           in   5   byte address; word index = bus_addr[4:2]
//  bus_we             in   1   write strobe, 1 cycle
//  bus_re             in   1   read strobe, 1 cycle
//  bus_wdata          in   32  write data
//  bus_rdata          out  32  read data, registered
//  upd_evt            in   1   1-cycle pulse from tim: counter wrap / period end
//  tim_rst            out  1   reset to tim core
//  tim_prescaler      out  W   active prescaler
//  tim_counter_mode   out  2   active mode: 00 up, 01 down, 10 center (11 reserved -> treated as 00)
//  tim_counter_period out  W   active period (ARR)
//  tim_pulse          out  W   active compare (CCR)
//  irq                out  1   UIF & UIE, level
// BEHAVIOUR
//  Reset: all regs 0; bus_rdata=0; tim_rst=1; irq=0; FSM=IDLE.
//  Map (word idx): 0 CTRL{[5]UG w1 self-clr, [4:3]MODE, [2]ARPE, [1]OPM, [0]EN}; 1 PSC; 2 ARR;
//   3 CCR; 4 SR{[0]UIF, W1C}; 5 DIER{[0]UIE}. Unmapped: read 0, write ignored. Unused bits read 0.
//  Read: bus_rdata valid the cycle after bus_re, holds until next read. PSC/ARR/CCR read preload.
//  Write: takes effect the cycle after bus_we. ARPE=0: PSC/ARR/CCR write updates preload+active.
//   ARPE=1: write updates preload only; active loaded on next update.
//  Update = upd_evt in RUN, or UG write. Update: active<=preload (all three), UIF<=1.
//  FSM:
//   IDLE:    tim_rst=1. EN 0->1 -> load active PSC/ARR/CCR+MODE from preload, cnt=0, -> RESTART.
//   RESTART: tim_rst=1 for exactly RST_CYCLES cycles, then -> RUN. upd_evt ignored.
//   RUN:     tim_rst=0. EN cleared -> IDLE (next cycle). MODE written with new value -> active
//            MODE updated, -> RESTART. UG -> update + RESTART. upd_evt -> update; if OPM: EN<=0, -> IDLE.
//  UG in IDLE/RESTART: update (active load, UIF=1), no state change.
//  Boundaries:
//   - upd_evt same cycle as ARR write (ARPE=1): active gets old preload; new value on next event.
//   - UIF set and W1C same cycle: set wins.
//   - EN clear and upd_evt same cycle: -> IDLE, UIF still set.
//   - MODE write with unchanged value in RUN: no restart.
//   - Active ARR==0 in RUN: tim_rst held 1 until ARR nonzero (no restart count); no upd_evt expected.
//   - PSC=0 legal, passed through.
//   - rst mid-RESTART/RUN: immediate return to reset values, all config lost.
//   - Wdata bits above W ignored on PSC/ARR/CCR.
// STRUCTURE
//  tim_pkg: typedef enum logic[1:0] {TIM_UP=2'b00, TIM_DOWN=2'b01, TIM_CENTER=2'b10} tim_mode_t;
//   register word-index localparams (TIM_CTRL..TIM_DIER); CTRL bit positions; FSM state enum.
//  Single module: bus decode, preload/active regs, FSM, restart counter. No sub-module needed.
// TESTING
//  1 Reset, then read all 6 regs -> all 0; tim_rst=1, irq=0.
//  2 PSC=2, ARR=10, CCR=5, CTRL=0x01 -> tim_rst high exactly 2 cycles, then 0; active outputs 2/10/5.
//  3 ARPE=1, RUN, write ARR=20 -> tim_counter_period stays 10 until upd_evt, then 20; SR.UIF=1;
//    UIE=1 -> irq=1; write SR=1 -> irq=0 next cycle.
//  4 RUN, write CTRL MODE=01 -> tim_rst re-pulses 2 cycles, tim_counter_mode=01; repeat with MODE=10.
//  5 OPM=1, EN=1 -> after first upd_evt: EN reads 0, tim_rst=1, UIF=1.
//  6 upd_evt and SR W1C in the same cycle -> UIF remains 1; ARR write in the same cycle as upd_evt
//    (ARPE=1) -> old preload applied.

Source files
------------

// File: rtl/tim_pkg.sv
// tim_pkg: shared types and constants for the PWM timer control front-end.
//   - tim_mode_t    : counting direction of the timer core
//   - TIM_* indices : register word indices (bus_addr[4:2])
//   - CTRL_* / SR_* / DIER_* : bit positions inside the control/status words
//   - tim_state_t   : control sequencer states
//   - mode_sanitize : maps the reserved mode encoding onto up-counting
package tim_pkg;

    typedef enum logic [1:0] {
        TIM_UP     = 2'b00,
        TIM_DOWN   = 2'b01,
        TIM_CENTER = 2'b10
    } tim_mode_t;

    localparam logic [2:0] TIM_CTRL = 3'd0;
    localparam logic [2:0] TIM_PSC  = 3'd1;
    localparam logic [2:0] TIM_ARR  = 3'd2;
    localparam logic [2:0] TIM_CCR  = 3'd3;
    localparam logic [2:0] TIM_SR   = 3'd4;
    localparam logic [2:0] TIM_DIER = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_OPM     = 1;
    localparam int CTRL_ARPE    = 2;
    localparam int CTRL_MODE_LO = 3;
    localparam int CTRL_MODE_HI = 4;
    localparam int CTRL_UG      = 5;
    localparam int SR_UIF       = 0;
    localparam int DIER_UIE     = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RESTART = 2'b01,
        ST_RUN     = 2'b10
    } tim_state_t;

    // The reserved encoding 2'b11 is driven to the core as up-counting.
    function automatic logic [1:0] mode_sanitize(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'b00:   r = TIM_UP;
            2'b01:   r = TIM_DOWN;
            2'b10:   r = TIM_CENTER;
            default: r = TIM_UP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tim_ctrl.sv
// tim_ctrl: memory-mapped control front-end for the PWM timer core.
// Holds preload/active PSC/ARR/CCR, transfers them on update events, and
// sequences the core reset on enable, mode change and software update.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   bus_addr/we/re/wdata  : register bus (word index = bus_addr[4:2])
//   bus_rdata             : registered read data, valid cycle after bus_re
//   upd_evt               : period-end pulse from the timer core
//   tim_rst               : reset to the timer core
//   tim_prescaler/_counter_mode/_counter_period/_pulse : active config
//   irq                   : update interrupt level (UIF & UIE)
module tim_ctrl
    import tim_pkg::*;
#(
    parameter int W          = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    bus_addr,
    input  logic          bus_we,
    input  logic          bus_re,
    input  logic [31:0]   bus_wdata,
    output logic [31:0]   bus_rdata,
    input  logic          upd_evt,
    output logic          tim_rst,
    output logic [W-1:0]  tim_prescaler,
    output logic [1:0]    tim_counter_mode,
    output logic [W-1:0]  tim_counter_period,
    output logic [W-1:0]  tim_pulse,
    output logic          irq
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    tim_state_t state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic en_r, en_nx, opm_r, opm_nx, arpe_r, arpe_nx;
    logic [1:0] mode_r, mode_nx, mode_act_r, mode_act_nx;
    logic [W-1:0] psc_pre_r, psc_pre_nx, arr_pre_r, arr_pre_nx, ccr_pre_r, ccr_pre_nx;
    logic [W-1:0] psc_act_r, psc_act_nx, arr_act_r, arr_act_nx, ccr_act_r, ccr_act_nx;
    logic uif_r, uif_nx, uie_r, uie_nx;
    logic tim_rst_r, tim_rst_nx, irq_r, irq_nx;
    logic [31:0] rdata_r, rdata_nx;

    logic [2:0] word_s;
    logic wr_ctrl_s, wr_psc_s, wr_arr_s, wr_ccr_s, wr_sr_s, wr_dier_s;
    logic ug_s, mode_chg_s, do_upd_s;
    logic [W-1:0] wdata_w_s;
    logic unused_s;

    assign word_s    = bus_addr[4:2];
    assign wdata_w_s = bus_wdata[W-1:0];
    assign unused_s  = ^{bus_addr[1:0], bus_wdata};

    // Bus decode, register updates, sequencer next state and output next values.
    always_comb begin
        state_nx    = state_r;
        cnt_nx      = cnt_r;
        en_nx       = en_r;
        opm_nx      = opm_r;
        arpe_nx     = arpe_r;
        mode_nx     = mode_r;
        mode_act_nx = mode_act_r;
        psc_pre_nx  = psc_pre_r;
        arr_pre_nx  = arr_pre_r;
        ccr_pre_nx  = ccr_pre_r;
        psc_act_nx  = psc_act_r;
        arr_act_nx  = arr_act_r;
        ccr_act_nx  = ccr_act_r;
        uif_nx      = uif_r;
        uie_nx      = uie_r;
        rdata_nx    = rdata_r;

        wr_ctrl_s  = bus_we && (word_s == TIM_CTRL);
        wr_psc_s   = bus_we && (word_s == TIM_PSC);
        wr_arr_s   = bus_we && (word_s == TIM_ARR);
        wr_ccr_s   = bus_we && (word_s == TIM_CCR);
        wr_sr_s    = bus_we && (word_s == TIM_SR);
        wr_dier_s  = bus_we && (word_s == TIM_DIER);
        ug_s       = wr_ctrl_s && bus_wdata[CTRL_UG];
        mode_chg_s = wr_ctrl_s && (bus_wdata[CTRL_MODE_HI:CTRL_MODE_LO] != mode_r);
        do_upd_s   = ug_s || (upd_evt && (state_r == ST_RUN));

        if (wr_ctrl_s) begin
            en_nx   = bus_wdata[CTRL_EN];
            opm_nx  = bus_wdata[CTRL_OPM];
            arpe_nx = bus_wdata[CTRL_ARPE];
            mode_nx = bus_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        end else begin
            en_nx = en_r;
        end

        if (wr_dier_s) begin
            uie_nx = bus_wdata[DIER_UIE];
        end else begin
            uie_nx = uie_r;
        end

        // W1C first so that a coincident update re-sets the flag.
        if (wr_sr_s && bus_wdata[SR_UIF]) begin
            uif_nx = 1'b0;
        end else begin
            uif_nx = uif_r;
        end

        // Update transfer reads the old preload, so a coincident preload
        // write only reaches the active copy on the following update.
        if (do_upd_s) begin
            psc_act_nx = psc_pre_r;
            arr_act_nx = arr_pre_r;
            ccr_act_nx = ccr_pre_r;
            uif_nx     = 1'b1;
        end else begin
            uif_nx = uif_nx;
        end

        // Without auto-reload preload, writes hit the active copy directly.
        if (wr_psc_s) begin
            psc_pre_nx = wdata_w_s;
            psc_act_nx = arpe_r ? psc_act_nx : wdata_w_s;
        end else if (wr_arr_s) begin
            arr_pre_nx = wdata_w_s;
            arr_act_nx = arpe_r ? arr_act_nx : wdata_w_s;
        end else if (wr_ccr_s) begin
            ccr_pre_nx = wdata_w_s;
            ccr_act_nx = arpe_r ? ccr_act_nx : wdata_w_s;
        end else begin
            psc_pre_nx = psc_pre_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (wr_ctrl_s && bus_wdata[CTRL_EN] && !en_r) begin
                    psc_act_nx  = psc_pre_r;
                    arr_act_nx  = arr_pre_r;
                    ccr_act_nx  = ccr_pre_r;
                    mode_act_nx = mode_sanitize(mode_nx);
                    cnt_nx      = {CNT_W{1'b0}};
                    state_nx    = ST_RESTART;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RESTART: begin
                if (!en_nx) begin
                    state_nx = ST_IDLE;
                end else if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
                    state_nx = ST_RUN;
                end else begin
                    cnt_nx = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (!en_nx) begin
                    state_nx = ST_IDLE;
                end else if (ug_s || mode_chg_s) begin
                    mode_act_nx = mode_sanitize(mode_nx);
                    cnt_nx      = {CNT_W{1'b0}};
                    state_nx    = ST_RESTART;
                end else if (upd_evt && opm_r) begin
                    en_nx    = 1'b0;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (bus_re) begin
            case (word_s)
                TIM_CTRL: rdata_nx = {26'd0, 1'b0, mode_r, arpe_r, opm_r, en_r};
                TIM_PSC:  rdata_nx = 32'(psc_pre_r);
                TIM_ARR:  rdata_nx = 32'(arr_pre_r);
                TIM_CCR:  rdata_nx = 32'(ccr_pre_r);
                TIM_SR:   rdata_nx = {31'd0, uif_r};
                TIM_DIER: rdata_nx = {31'd0, uie_r};
                default:  rdata_nx = 32'd0;
            endcase
        end else begin
            rdata_nx = rdata_r;
        end

        // A zero period holds the core in reset without a restart sequence.
        tim_rst_nx = (state_nx != ST_RUN) || (arr_act_nx == {W{1'b0}});
        irq_nx     = uif_nx & uie_nx;
    end

    // State and configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            en_r       <= 1'b0;
            opm_r      <= 1'b0;
            arpe_r     <= 1'b0;
            mode_r     <= 2'b00;
            mode_act_r <= 2'b00;
            psc_pre_r  <= {W{1'b0}};
            arr_pre_r  <= {W{1'b0}};
            ccr_pre_r  <= {W{1'b0}};
            psc_act_r  <= {W{1'b0}};
            arr_act_r  <= {W{1'b0}};
            ccr_act_r  <= {W{1'b0}};
            uif_r      <= 1'b0;
            uie_r      <= 1'b0;
            tim_rst_r  <= 1'b1;
            irq_r      <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            state_r    <= state_nx;
            cnt_r      <= cnt_nx;
            en_r       <= en_nx;
            opm_r      <= opm_nx;
            arpe_r     <= arpe_nx;
            mode_r     <= mode_nx;
            mode_act_r <= mode_act_nx;
            psc_pre_r  <= psc_pre_nx;
            arr_pre_r  <= arr_pre_nx;
            ccr_pre_r  <= ccr_pre_nx;
            psc_act_r  <= psc_act_nx;
            arr_act_r  <= arr_act_nx;
            ccr_act_r  <= ccr_act_nx;
            uif_r      <= uif_nx;
            uie_r      <= uie_nx;
            tim_rst_r  <= tim_rst_nx;
            irq_r      <= irq_nx;
            rdata_r    <= rdata_nx;
        end
    end

    assign bus_rdata          = rdata_r;
    assign tim_rst            = tim_rst_r;
    assign tim_prescaler      = psc_act_r;
    assign tim_counter_mode   = mode_act_r;
    assign tim_counter_period = arr_act_r;
    assign tim_pulse          = ccr_act_r;
    assign irq                = irq_r;

endmodule

// File: tb/tb_tim_ctrl.sv
// tb_tim_ctrl: directed self-checking bench for tim_ctrl. Expected read data
// is queued when a read is issued and compared when bus_rdata is produced.
module tb_tim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  bus_addr;
    logic        bus_we, bus_re, upd_evt;
    logic [31:0] bus_wdata, bus_rdata;
    logic        tim_rst, irq;
    logic [15:0] tim_prescaler, tim_counter_period, tim_pulse;
    logic [1:0]  tim_counter_mode;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    localparam logic [4:0] A_CTRL = 5'd0, A_PSC = 5'd4, A_ARR = 5'd8;
    localparam logic [4:0] A_CCR = 5'd12, A_SR = 5'd16, A_DIER = 5'd20, A_UNM = 5'd24;

    tim_ctrl #(.W(16), .RST_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .upd_evt(upd_evt), .tim_rst(tim_rst),
        .tim_prescaler(tim_prescaler), .tim_counter_mode(tim_counter_mode),
        .tim_counter_period(tim_counter_period), .tim_pulse(tim_pulse),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic wr_upd(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1; upd_evt = 1'b1;
        @(negedge clk);
        bus_we = 1'b0; upd_evt = 1'b0;
    endtask

    task automatic pulse_upd();
        @(negedge clk);
        upd_evt = 1'b1;
        @(negedge clk);
        upd_evt = 1'b0;
    endtask

    task automatic pop_cmp();
        sb_t s;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            s = sb_q.pop_front();
            check(s.tag, bus_rdata, s.exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        sb_q.push_back('{tag, exp});
        @(negedge clk);
        bus_addr = a; bus_re = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        pop_cmp();
    endtask

    // Expect tim_rst high now and next cycle, low the cycle after.
    task automatic chk_restart(input string tag);
        check({tag, "_rst0"}, 32'(tim_rst), 32'd1);
        step();
        check({tag, "_rst1"}, 32'(tim_rst), 32'd1);
        step();
        check({tag, "_rst2"}, 32'(tim_rst), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bus_addr = 5'd0; bus_we = 1'b0; bus_re = 1'b0;
        bus_wdata = 32'd0; upd_evt = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state and register readback.
        check("rst_tim_rst", 32'(tim_rst), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        rd(A_CTRL, 32'd0, "rst_ctrl");
        rd(A_PSC, 32'd0, "rst_psc");
        rd(A_ARR, 32'd0, "rst_arr");
        rd(A_CCR, 32'd0, "rst_ccr");
        rd(A_SR, 32'd0, "rst_sr");
        rd(A_DIER, 32'd0, "rst_dier");

        // Configure and enable; upper PSC bits beyond W dropped.
        wr(A_PSC, 32'h0003_0002);
        wr(A_ARR, 32'd10);
        wr(A_CCR, 32'd5);
        rd(A_PSC, 32'd2, "psc_trunc");
        wr(A_UNM, 32'hFFFF_FFFF);
        rd(A_UNM, 32'd0, "unmapped");
        wr(A_CTRL, 32'h01);
        chk_restart("en");
        check("en_psc", 32'(tim_prescaler), 32'd2);
        check("en_arr", 32'(tim_counter_period), 32'd10);
        check("en_ccr", 32'(tim_pulse), 32'd5);

        // ARPE: preload only until update.
        wr(A_CTRL, 32'h05);
        check("same_mode_norestart", 32'(tim_rst), 32'd0);
        wr(A_ARR, 32'd20);
        check("arpe_hold", 32'(tim_counter_period), 32'd10);
        rd(A_ARR, 32'd20, "arr_preload");
        pulse_upd();
        check("arpe_upd", 32'(tim_counter_period), 32'd20);
        rd(A_SR, 32'd1, "uif_set");
        check("irq_masked", 32'(irq), 32'd0);
        wr(A_DIER, 32'd1);
        check("irq_on", 32'(irq), 32'd1);
        wr(A_SR, 32'd1);
        check("irq_clr", 32'(irq), 32'd0);
        rd(A_SR, 32'd0, "uif_clr");

        // Mode changes restart the core.
        wr(A_CTRL, 32'h0D);
        check("mode01", 32'(tim_counter_mode), 32'd1);
        chk_restart("mode01");
        wr(A_CTRL, 32'h15);
        check("mode10", 32'(tim_counter_mode), 32'd2);
        chk_restart("mode10");
        wr(A_CTRL, 32'h1D);
        check("mode11_as_up", 32'(tim_counter_mode), 32'd0);
        rd(A_CTRL, 32'h1D, "ctrl_mode11");
        wr(A_CTRL, 32'h05);
        chk_restart("mode00");

        // Set beats W1C; preload write coincident with update.
        wr_upd(A_SR, 32'd1);
        rd(A_SR, 32'd1, "set_wins");
        check("irq_set_wins", 32'(irq), 32'd1);
        wr(A_ARR, 32'd30);
        wr_upd(A_ARR, 32'd40);
        check("arr_old_preload", 32'(tim_counter_period), 32'd30);
        pulse_upd();
        check("arr_new_preload", 32'(tim_counter_period), 32'd40);

        // Software update in RUN: load + restart, UG self-clears.
        wr(A_ARR, 32'd50);
        wr(A_CTRL, 32'h25);
        check("ug_arr", 32'(tim_counter_period), 32'd50);
        chk_restart("ug");
        rd(A_CTRL, 32'h05, "ug_selfclr");

        // Zero period holds reset; nonzero releases without restart count.
        wr(A_ARR, 32'd0);
        pulse_upd();
        check("arr0_hold", 32'(tim_rst), 32'd1);
        wr(A_CTRL, 32'h01);
        wr(A_ARR, 32'd7);
        check("arr7_release", 32'(tim_rst), 32'd0);
        check("arr7_val", 32'(tim_counter_period), 32'd7);

        // EN clear coincident with update.
        wr(A_SR, 32'd1);
        wr_upd(A_CTRL, 32'h00);
        check("enclr_idle", 32'(tim_rst), 32'd1);
        rd(A_SR, 32'd1, "enclr_uif");

        // One-pulse mode.
        wr(A_CTRL, 32'h03);
        chk_restart("opm");
        wr(A_SR, 32'd1);
        pulse_upd();
        check("opm_rst", 32'(tim_rst), 32'd1);
        check("opm_irq", 32'(irq), 32'd1);
        rd(A_CTRL, 32'h02, "opm_en_clr");
        rd(A_SR, 32'd1, "opm_uif");

        // PSC=0 passed through directly.
        wr(A_PSC, 32'd0);
        check("psc0", 32'(tim_prescaler), 32'd0);

        // Reset mid-restart drops all config.
        wr(A_PSC, 32'd9);
        wr(A_CTRL, 32'h01);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tim_rst", 32'(tim_rst), 32'd1);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_psc", 32'(tim_prescaler), 32'd0);
        check("mid_rst_arr", 32'(tim_counter_period), 32'd0);
        rd(A_CTRL, 32'd0, "mid_rst_ctrl");
        rd(A_DIER, 32'd0, "mid_rst_dier");
        rd(A_PSC, 32'd0, "mid_rst_psc_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
